uart_rx_fifo_engine: RTL
========================

Name: uart_rx_fifo_engine

Overview:
Parametrised UART receive engine for the next-generation UART top. It takes an oversampling baud tick and the serial rx line, deframes characters with a runtime-selectable format, and stores each character with its error flags in a first-word-fall-through FIFO. It also reports overrun, break and FIFO-threshold status to the interrupt logic and the register file. Compared with the current receiver it adds a parametrised oversampling ratio and FIFO depth, per-entry error tagging, glitch rejection and break detection.

Parameters:
OVERSAMPLE, 16, baud_tick_i pulses per bit time; must be even and ≥ 4.
FIFO_DEPTH, 16, number of entries; must be a power of two and ≥ 2.
CW, $clog2(FIFO_DEPTH)+1, width of the count and threshold fields (derived).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  receiver enable
baud_tick_i  in  1  one-cycle oversample tick
rx_i  in  1  asynchronous serial input, idle high
data_width_i  in  2  00=5, 01=6, 10=7, 11=8 data bits
parity_mode_i  in  2  00=even, 01=odd, 1x=none
stop_bits_i  in  1  0=one stop bit, 1=two stop bits
threshold_i  in  CW  FIFO level threshold; 0 disables
rd_i  in  1  pop the head entry
clear_overrun_i  in  1  clear the overrun flag
data_o  out  8  head data, zero-extended above the selected width
frame_error_o  out  1  head entry frame-error tag
parity_error_o  out  1  head entry parity-error tag
fifo_empty_o  out  1  FIFO is empty
fifo_full_o  out  1  FIFO is full
fifo_count_o  out  CW  number of valid entries
threshold_o  out  1  FIFO level has reached threshold
overrun_o  out  1  sticky overrun flag
break_o  out  1  one-cycle break pulse
rx_busy_o  out  1  a frame is in progress

Behaviour:
- Reset values: fifo_empty_o=1; all other outputs 0; FSM in IDLE; synchroniser flops reset to 1.
- rx_i passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- The tick counter counts baud_tick_i pulses only. It is cleared on every state transition.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH, WAIT_IDLE.
- IDLE:
  - A synchronised falling edge moves to START.
  - rx_busy_o=1 in every state except IDLE.
- START:
  - At tick OVERSAMPLE/2, the line is sampled.
  - Low: latch data_width_i, parity_mode_i and stop_bits_i for this frame, then go to DATA.
  - High: treat as a glitch and return to IDLE with no push.
  - Config input changes after the latch have no effect on the current frame.
- DATA:
  - Sample every OVERSAMPLE ticks (mid-bit), LSB first, for the latched width.
  - Then go to PARITY if parity is enabled, otherwise STOP1.
- PARITY:
  - Sample the parity bit.
  - parity_err = XOR(data bits, parity bit) differs from the expected value (even: expect 0; odd: expect 1).
- STOP1: sample the stop bit; 0 sets frame_err. Go to STOP2 if two stop bits are latched, else PUSH.
- STOP2: same check as STOP1; 0 also sets frame_err.
- Break: all data bits, the parity bit (if enabled) and STOP1 all sampled 0.
  - break_o pulses for 1 cycle in PUSH.
  - The entry is stored as data=0x00 with frame_err=1.
  - The FSM then goes to WAIT_IDLE instead of IDLE.
- WAIT_IDLE: return to IDLE only after a synchronised 1 is seen.
- PUSH:
  - Lasts exactly 1 clock.
  - Writes {frame_err, parity_err, data} to the FIFO.
  - The entry is visible on the outputs the next cycle, i.e. 2 clocks after the final stop-sample tick.
- FIFO write/read rules:
  - A push is accepted if !fifo_full_o, or if rd_i is asserted in the same cycle.
  - Otherwise the frame is dropped, overrun_o is set and existing entries are untouched.
  - rd_i while empty is ignored.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Head outputs: data_o, frame_error_o and parity_error_o show the head entry combinationally and read as 0 when empty.
- threshold_o = (threshold_i != 0) && (fifo_count_o ≥ threshold_i), registered.
- overrun_o stays set until clear_overrun_i. If a new overrun and clear_overrun_i occur in the same cycle, the set wins.
- enable_i low:
  - The FSM returns to IDLE on the next clock and any partial frame is discarded without a push.
  - FIFO contents and rd_i remain functional.
  - A frame whose START falls while disabled is not received.
- rst_i asserted mid-frame or mid-FIFO operation returns everything to the reset values on the next edge.

Test Plan:
- Frame format 8N1 (8 data bits, no parity, 1 stop bit), OVERSAMPLE=16, send 0xA5 → 2 clocks after the stop-sample tick: fifo_empty_o=0, data_o=0xA5, both error tags 0, fifo_count_o=1. After rd_i: fifo_empty_o=1, data_o=0x00.
- 7 bits, even parity, 0x35 sent with parity bit 1 → data_o=0x35, parity_error_o=1. Same frame with parity bit 0 → parity_error_o=0. Also send 5 bits 0x1F, 2 stop bits, second stop bit 0 → data_o=0x1F, frame_error_o=1.
- rx_i low for 5 ticks, then high → no push, rx_busy_o returns to 0, fifo_count_o stays 0.
- FIFO_DEPTH=4, five frames 0x01..0x05 with no reads → fifo_full_o=1, fifo_count_o=4, overrun_o=1, heads read out in order 0x01..0x04. A sixth frame arriving in the same cycle as rd_i is accepted. clear_overrun_i → overrun_o=0.
- rx_i held low for 12 bit times → one break_o pulse, one entry with data 0x00 and frame_error_o=1, no further entries until rx_i goes high, then a normal frame 0x3C is received correctly.
- enable_i dropped during DATA → no push, rx_busy_o=0 next cycle. Separately, rst_i asserted with 3 entries queued → fifo_count_o=0, fifo_empty_o=1, overrun_o=0 after one clock.

Source files
------------

// File: rtl/uart_rx_fifo_engine.sv
// UART receive engine: 2-flop synchroniser, oversampled deframer with
// runtime format select, break/glitch handling, and a FWFT FIFO whose
// entries carry {frame_err, parity_err, data}.
// Ports: clk_i/rst_i (sync, active-high), enable_i, baud_tick_i, rx_i,
// data_width_i, parity_mode_i, stop_bits_i, threshold_i, rd_i,
// clear_overrun_i -> data_o, frame_error_o, parity_error_o,
// fifo_empty_o, fifo_full_o, fifo_count_o, threshold_o, overrun_o,
// break_o, rx_busy_o.
module uart_rx_fifo_engine #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          baud_tick_i,
  input  logic          rx_i,
  input  logic [1:0]    data_width_i,
  input  logic [1:0]    parity_mode_i,
  input  logic          stop_bits_i,
  input  logic [CW-1:0] threshold_i,
  input  logic          rd_i,
  input  logic          clear_overrun_i,
  output logic [7:0]    data_o,
  output logic          frame_error_o,
  output logic          parity_error_o,
  output logic          fifo_empty_o,
  output logic          fifo_full_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          threshold_o,
  output logic          overrun_o,
  output logic          break_o,
  output logic          rx_busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY,
    S_STOP1, S_STOP2, S_PUSH, S_WAIT
  } state_t;

  state_t        state;
  logic [2:0]    sync;
  logic          rx_s;
  logic          fall;
  logic [TW-1:0] tick_cnt;
  logic          mid;
  logic [2:0]    bit_idx;
  logic [2:0]    last_idx;
  logic [7:0]    shreg;
  logic [1:0]    dw;
  logic [1:0]    pm;
  logic          two_stop;
  logic          par_acc;
  logic          any_one;
  logic          frame_err;
  logic          parity_err;
  logic          brk;

  // sync[2] is the previous synchronised sample, for edge detection
  assign rx_s = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign mid = baud_tick_i && (tick_cnt == FULL_M1);
  assign last_idx = {1'b1, dw};
  assign rx_busy_o = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) sync <= '1;
    else sync <= {sync[1:0], rx_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      dw         <= '0;
      pm         <= '0;
      two_stop   <= 1'b0;
      par_acc    <= 1'b0;
      any_one    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      brk        <= 1'b0;
      break_o    <= 1'b0;
    end else if (!enable_i) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      break_o  <= 1'b0;
    end else begin
      break_o <= 1'b0;
      if (baud_tick_i) tick_cnt <= tick_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (fall) begin
            state    <= S_START;
            tick_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_tick_i && tick_cnt == HALF_M1) begin
            tick_cnt <= '0;
            if (!rx_s) begin
              state      <= S_DATA;
              dw         <= data_width_i;
              pm         <= parity_mode_i;
              two_stop   <= stop_bits_i;
              bit_idx    <= '0;
              shreg      <= '0;
              par_acc    <= 1'b0;
              any_one    <= 1'b0;
              frame_err  <= 1'b0;
              parity_err <= 1'b0;
              brk        <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (mid) begin
            tick_cnt       <= '0;
            shreg[bit_idx] <= rx_s;
            par_acc        <= par_acc ^ rx_s;
            any_one        <= any_one | rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == last_idx)
              state <= pm[1] ? S_STOP1 : S_PARITY;
          end
        end
        S_PARITY: begin
          if (mid) begin
            tick_cnt   <= '0;
            parity_err <= (par_acc ^ rx_s) != pm[0];
            any_one    <= any_one | rx_s;
            state      <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (mid) begin
            tick_cnt <= '0;
            if (!rx_s && !any_one) begin
              // break: all-zero frame, stored as a framing error
              brk        <= 1'b1;
              frame_err  <= 1'b1;
              parity_err <= 1'b0;
              break_o    <= 1'b1;
              state      <= S_PUSH;
            end else begin
              frame_err <= frame_err | ~rx_s;
              state     <= two_stop ? S_STOP2 : S_PUSH;
            end
          end
        end
        S_STOP2: begin
          if (mid) begin
            tick_cnt  <= '0;
            frame_err <= frame_err | ~rx_s;
            state     <= S_PUSH;
          end
        end
        S_PUSH: begin
          tick_cnt <= '0;
          state    <= brk ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (rx_s) begin
            tick_cnt <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          accept;

  assign push = (state == S_PUSH);
  assign fifo_empty_o = (fifo_count_o == '0);
  assign fifo_full_o = (fifo_count_o == DEPTH);
  assign pop = rd_i && !fifo_empty_o;
  // a pop in the same cycle frees the slot being written
  assign accept = push && (!fifo_full_o || rd_i);

  assign head = mem[rd_ptr];
  assign data_o = fifo_empty_o ? 8'h00 : head[7:0];
  assign parity_error_o = !fifo_empty_o && head[8];
  assign frame_error_o = !fifo_empty_o && head[9];

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= {frame_err, parity_err, shreg};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      overrun_o    <= 1'b0;
      threshold_o  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        accept && !pop: fifo_count_o <= fifo_count_o + 1'b1;
        pop && !accept: fifo_count_o <= fifo_count_o - 1'b1;
        default: ;
      endcase
      if (push && !accept) overrun_o <= 1'b1;
      else if (clear_overrun_i) overrun_o <= 1'b0;
      threshold_o <= (threshold_i != '0) &&
                     (fifo_count_o >= threshold_i);
    end
  end

endmodule
